// File: rtl/bit_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_pkg
//
// Purpose:
//   Shared constants for the sequential adders in the adder library.
//   Holds the FSM state encodings and the default operand width. The
//   shift-add multiplier that will sit on top of bit_serial_adder is
//   expected to import this same package, so the encodings below must stay
//   stable.
//
// Contents:
//   DEFAULT_WIDTH  default operand / sum width (bits)
//   state_t        2-bit FSM state type
//   ST_IDLE        waiting for start, result registers hold the last result
//   ST_RUN         one operand bit pair processed per clock, LSB first
//   ST_DONE        one-cycle completion state; a new start is accepted here
// -----------------------------------------------------------------------------
package bit_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage : bit_serial_adder_pkg

// File: rtl/bit_serial_adder_fa.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_fa
//
// Purpose:
//   Single-bit full-adder cell of the adder library. Purely combinational.
//   The serial adder instantiates exactly one of these and time-multiplexes
//   it over all operand bits.
//
// Ports:
//   a      in   1  operand bit A
//   b      in   1  operand bit B
//   c_in   in   1  carry in
//   c_out  out  1  carry out
//   out    out  1  sum bit
// -----------------------------------------------------------------------------
module bit_serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic out
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign out     = a_xor_b ^ c_in;
    assign c_out   = (a & b) | (a_xor_b & c_in);

endmodule : bit_serial_adder_fa

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// Purpose:
//   Multi-cycle adder that adds two WIDTH-bit operands one bit per clock,
//   LSB first, using a single full-adder cell and a registered carry.
//   {c_out, sum} = a + b (unsigned). The result registers only change on
//   completion or reset; partial sums never reach the outputs.
//
// Timing:
//   The start-accept edge is edge 0. The operand bits are consumed on edges
//   1..WIDTH; sum/c_out update on edge WIDTH and done is high for the cycle
//   after it. A start seen in DONE is accepted immediately, giving one add
//   every WIDTH+1 cycles back-to-back. start is ignored while busy.
//
// Handshake:
//   ready=1 (IDLE or DONE) means a start at the next rising edge is accepted
//   and a/b (and sub) are captured on that edge; nothing is queued while
//   ready=0. done is a single-cycle pulse, no acknowledge is required.
//
// Configuration:
//   BIT_SERIAL_ADDER_SUB_EN - when defined, adds input 'sub'. With sub=1 the
//   B operand is loaded inverted and the initial carry is 1, so
//   sum = a - b (mod 2^WIDTH) and c_out=1 means no borrow (a >= b).
//   Timing is identical in both builds.
//
// Parameters:
//   WIDTH  operand and sum width, 2..32 (default DEFAULT_WIDTH = 8)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      request, sampled only when ready=1
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      subtract select (BIT_SERIAL_ADDER_SUB_EN only)
//   ready      out  1      high in IDLE and DONE
//   busy       out  1      high in RUN
//   done       out  1      one-cycle completion pulse
//   sum        out  WIDTH  registered result
//   c_out      out  1      registered final carry
//   state_dbg  out  2      current FSM state (debug observation)
// -----------------------------------------------------------------------------
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output state_t           state_dbg
);

    // The counter only needs to reach WIDTH-1; it saturates there rather
    // than wrapping, and is reloaded on every accepted start.
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             cnt_last;
    logic             fa_out;
    logic             fa_cout;
    logic [WIDTH-1:0] s_sh_nxt;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // -------------------------------------------------------------------------
    // Operand conditioning at load time
    // -------------------------------------------------------------------------
`ifdef BIT_SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1. The +1 rides in on the carry.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub;
`else
    assign b_load     = b;
    assign carry_load = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Arithmetic: the single FA cell, fed from the LSBs of the shifters
    // -------------------------------------------------------------------------
    bit_serial_adder_fa u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .c_out (fa_cout),
        .out   (fa_out)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the first (LSB)
    // result bit has travelled down to bit 0.
    assign s_sh_nxt = {fa_out, s_sh[WIDTH-1:1]};

    assign accept   = ready && start;
    assign cnt_last = (cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back: a start here begins the next add directly.
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode
    // -------------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_RUN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Datapath: shifters, carry, counter and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_sh_nxt;
            carry <= fa_cout;
            if (cnt_last) begin
                // Final bit: publish the full result including this bit.
                sum   <= s_sh_nxt;
                c_out <= fa_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : bit_serial_adder
